string_print_engine: RTL and testbench

- Syscall print_string (v0=4) sequencer. It takes ownership of the single data-memory port, reads a NUL-terminated string starting at a0 and emits the string one byte at a time to a console sink over a valid/ready handshake.
- It arbitrates the memory port between the CPU load/store path and itself. The CPU stalls on busy.
- It sits between the datapath's memory-access stage and Data_Memory.
- Data_Memory reads combinationally and writes on negedge. mem_size uses 0=word, 1=half, 2=byte.

---
 rtl/string_print_engine.sv | 111 +++++++++++
 tb/tb_string_print_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_print_engine.sv
// print_string syscall engine: owns the data-memory port while walking a
// NUL-terminated string and streams its bytes to a console over valid/ready.
module string_print_engine #(
   parameter int unsigned MAX_LEN = 1024,
   parameter logic [31:0] MEM_LO  = 32'h7FFF_FBFC,
   parameter logic [31:0] MEM_HI  = 32'h7FFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] str_addr,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic [31:0] cpu_mem_addr,
   input  logic        cpu_mem_read,
   input  logic        cpu_mem_write,
   input  logic [31:0] cpu_write_data,
   input  logic [1:0]  cpu_size,
   output logic [31:0] cpu_read_data,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_write_data,
   output logic [1:0]  mem_size,
   input  logic [31:0] mem_read_data,
   output logic [7:0]  char_data,
   output logic        char_valid,
   input  logic        char_ready
);

   typedef enum logic [1:0] {IDLE, FETCH, EMIT, FINISH} state_e;

   state_e      state_q;
   logic [31:0] ptr_q, count_q, word_q;
   logic        error_q;
   logic [32:0] ptr_d;
   logic [31:0] count_d;
   logic [7:0]  byte_sel;

   // One extra bit on the pointer increment so a wrap past 2^32 still trips MEM_HI.
   assign ptr_d    = {1'b0, ptr_q} + 33'd1;
   assign count_d  = count_q + 32'd1;
   assign byte_sel = word_q[{ptr_q[1:0], 3'b000} +: 8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         word_q  <= '0;
         error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               ptr_q   <= str_addr;
               count_q <= '0;
               if (str_addr < MEM_LO || str_addr > MEM_HI) begin
                  error_q <= 1'b1;
                  state_q <= FINISH;
               end else begin
                  error_q <= 1'b0;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               word_q  <= mem_read_data;
               state_q <= EMIT;
            end
            EMIT: if (byte_sel == 8'd0) begin
               state_q <= FINISH;
            end else if (char_ready) begin
               ptr_q   <= ptr_d[31:0];
               count_q <= count_d;
               if (count_d == 32'(MAX_LEN) || ptr_d > {1'b0, MEM_HI}) begin
                  error_q <= 1'b1;
                  state_q <= FINISH;
               end else if (ptr_q[1:0] == 2'd3) begin
                  state_q <= FETCH;
               end
            end
            FINISH: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);
   assign error         = error_q;
   assign char_valid    = (state_q == EMIT) && (byte_sel != 8'd0);
   assign char_data     = char_valid ? byte_sel : 8'd0;
   assign cpu_read_data = mem_read_data;

   // CPU owns the port only while idle; the engine issues word reads only.
   always_comb begin
      mem_addr       = cpu_mem_addr;
      mem_read       = cpu_mem_read;
      mem_write      = cpu_mem_write;
      mem_write_data = cpu_write_data;
      mem_size       = cpu_size;
      if (state_q != IDLE) begin
         mem_addr       = {ptr_q[31:2], 2'b00};
         mem_read       = (state_q == FETCH);
         mem_write      = 1'b0;
         mem_write_data = '0;
         mem_size       = 2'd0;
      end
   end

endmodule

// File: tb/tb_string_print_engine.sv
// Randomized self-checking bench: a string-walk reference model predicts the
// character stream, error flag and completion latency of each print.
module tb_string_print_engine;

   localparam logic [31:0] LO = 32'h7FFF_FBFC;
   localparam logic [31:0] HI = 32'h7FFF_FFFF;
   localparam logic [31:0] S0 = 32'h7FFF_FC00;

   typedef logic [7:0] bq_t[$];

   logic        clk, reset, start, start4;
   logic [31:0] str_addr;
   logic        busy, done, error, busy4, done4, error4;
   logic [31:0] cpu_mem_addr, cpu_write_data, cpu_read_data, cpu_read_data4;
   logic        cpu_mem_read, cpu_mem_write;
   logic [1:0]  cpu_size, mem_size, mem_size4;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic [31:0] mem_addr4, mem_write_data4, mem_read_data4;
   logic        mem_read, mem_write, mem_read4, mem_write4;
   logic [7:0]  char_data, char_data4;
   logic        char_valid, char_valid4, char_ready;

   logic [31:0] mem_w [0:256];
   int          checks, errors, cyc, st_cyc, exp_edges;
   int          rdy_mode;
   bit          op_active, done_seen, lat_chk, exp_err, last_err;
   bq_t         exp_q;
   logic [31:0] fetch_q[$];

   string_print_engine dut (
      .clk(clk), .reset(reset), .start(start), .str_addr(str_addr),
      .busy(busy), .done(done), .error(error),
      .cpu_mem_addr(cpu_mem_addr), .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_write_data(cpu_write_data), .cpu_size(cpu_size), .cpu_read_data(cpu_read_data),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_write_data(mem_write_data), .mem_size(mem_size), .mem_read_data(mem_read_data),
      .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready));

   string_print_engine #(.MAX_LEN(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .str_addr(S0),
      .busy(busy4), .done(done4), .error(error4),
      .cpu_mem_addr(32'd0), .cpu_mem_read(1'b0), .cpu_mem_write(1'b0),
      .cpu_write_data(32'd0), .cpu_size(2'd0), .cpu_read_data(cpu_read_data4),
      .mem_addr(mem_addr4), .mem_read(mem_read4), .mem_write(mem_write4),
      .mem_write_data(mem_write_data4), .mem_size(mem_size4), .mem_read_data(mem_read_data4),
      .char_data(char_data4), .char_valid(char_valid4), .char_ready(char_ready));

   function automatic int widx(input logic [31:0] a);
      return int'((a - LO) >> 2);
   endfunction

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (a >= LO && a <= HI) return mem_w[widx(a)];
      return 32'd0;
   endfunction

   assign mem_read_data  = rd(mem_addr);
   assign mem_read_data4 = rd(mem_addr4);

   // Data_Memory writes on the falling edge.
   always @(negedge clk)
      if (mem_write && mem_addr >= LO && mem_addr <= HI) mem_w[widx(mem_addr)] <= mem_write_data;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) char_ready = 1'b1;
         else if (rdy_mode == 1) char_ready = 1'($urandom_range(0, 1));
         else char_ready = 1'b0;
      end
   end

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Walk the string byte by byte from memory; edges = posedges from the
   // start edge to entering the done cycle (one fetch per word touched,
   // one cycle per character, one for the NUL check).
   task automatic model(input logic [31:0] a0, input int unsigned maxlen,
                        output bq_t q, output bit err, output int edges);
      logic [31:0] a, w;
      logic [7:0]  b;
      int          n;
      bit          nul;
      q = {};
      err = 0; edges = 0; n = 0; nul = 0;
      if (a0 < LO || a0 > HI) begin
         err = 1;
         return;
      end
      a = a0;
      while (n < 4096) begin
         w = rd({a[31:2], 2'b00});
         b = 8'(w >> (32'(a[1:0]) * 8));
         if (b == 8'd0) begin nul = 1; break; end
         q.push_back(b);
         n++;
         if (n == int'(maxlen)) begin err = 1; break; end
         if (a == HI) begin err = 1; break; end
         a = a + 32'd1;
      end
      edges = int'((a >> 2) - (a0 >> 2)) + 1 + n + (nul ? 1 : 0);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk(cpu_read_data == mem_read_data, "cpu_rd_mirror", cpu_read_data, mem_read_data);
         if (busy) chk(mem_write == 1'b0, "busy_no_write", 32'(mem_write), 32'd0);
         if (busy && mem_read) fetch_q.push_back(mem_addr);
         if (char_valid) begin
            chk(op_active && exp_q.size() != 0, "char_unexpected", 32'(char_data), 32'd0);
            if (op_active && exp_q.size() != 0) begin
               chk(char_data == exp_q[0], "char_data", 32'(char_data), 32'(exp_q[0]));
               if (char_ready) void'(exp_q.pop_front());
            end
         end
         if (done) begin
            chk(op_active, "done_unexpected", 32'(done), 32'd0);
            chk(exp_q.size() == 0, "chars_missing", 32'(exp_q.size()), 32'd0);
            chk(error == exp_err, "error_at_done", 32'(error), 32'(exp_err));
            if (lat_chk) chk(cyc - st_cyc == exp_edges, "latency", 32'(cyc - st_cyc), 32'(exp_edges));
            last_err = exp_err;
            op_active = 0;
            done_seen = 1;
         end else if (!busy && !op_active) begin
            chk(error == last_err, "error_sticky", 32'(error), 32'(last_err));
         end
      end
   end

   task automatic start_op(input logic [31:0] a, input bit lat);
      bq_t q;
      bit  e;
      int  ed;
      model(a, 1024, q, e, ed);
      exp_q = q; exp_err = e; exp_edges = ed; lat_chk = lat;
      fetch_q.delete();
      done_seen = 0;
      op_active = 1;
      start = 1'b1;
      str_addr = a;
      @(posedge clk);
      #1;
      start = 1'b0;
      st_cyc = cyc;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (!done_seen && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(done_seen, "done_timeout", 32'(n), 32'(bound));
   endtask

   function automatic logic [7:0] rbyte();
      if ($urandom_range(0, 5) == 0) return 8'd0;
      return 8'($urandom_range(1, 255));
   endfunction

   initial begin
      bq_t         q, got;
      bit          e;
      int          ed, n;
      logic [31:0] a;

      for (int i = 0; i <= 256; i++) mem_w[i] = 32'd0;
      reset = 1'b1; start = 1'b0; start4 = 1'b0; str_addr = '0;
      cpu_mem_addr = '0; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
      cpu_write_data = '0; cpu_size = 2'd0; rdy_mode = 0; char_ready = 1'b1;
      #1;
      chk(busy == 1'b0 && done == 1'b0, "reset_busy_done", {busy, done}, 32'd0);
      chk(error == 1'b0, "reset_error", 32'(error), 32'd0);
      chk(char_valid == 1'b0 && char_data == 8'd0, "reset_char", {char_valid, char_data}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // "Hi", word aligned
      mem_w[widx(S0)] = 32'h0000_6948;
      model(S0, 1024, q, e, ed);
      chk(q.size() == 2 && q[0] == 8'h48 && q[1] == 8'h69, "model_hi", 32'(q.size()), 32'd2);
      chk(ed == 4 && !e, "model_hi_latency", 32'(ed), 32'd4);
      start_op(S0, 1);
      wait_done(50);
      chk(fetch_q.size() == 1 && fetch_q[0] == S0, "hi_fetch", 32'(fetch_q.size()), 32'd1);

      // unaligned start crossing a word boundary
      mem_w[widx(S0)]     = 32'h4443_0000;
      mem_w[widx(S0) + 1] = 32'h0000_0045;
      model(S0 + 2, 1024, q, e, ed);
      chk(q.size() == 3 && q[0] == 8'h43 && q[2] == 8'h45, "model_unaligned", 32'(q.size()), 32'd3);
      start_op(S0 + 2, 1);
      wait_done(50);
      chk(fetch_q.size() == 2, "unaligned_fetch_cnt", 32'(fetch_q.size()), 32'd2);
      if (fetch_q.size() == 2) begin
         chk(fetch_q[0] == S0, "unaligned_fetch0", fetch_q[0], S0);
         chk(fetch_q[1] == S0 + 4, "unaligned_fetch1", fetch_q[1], S0 + 4);
      end

      // backpressure, with a blocked CPU store during the stall
      mem_w[widx(S0)] = 32'h0000_4241;
      rdy_mode = 2;
      start_op(S0, 0);
      n = 0;
      while (!char_valid && n < 10) begin @(negedge clk); n++; end
      cpu_mem_write = 1'b1; cpu_mem_addr = S0; cpu_write_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk(char_valid && char_data == 8'h41, "backpressure_hold", {char_valid, char_data}, 32'h141);
      end
      @(posedge clk); #1;
      cpu_mem_write = 1'b0;
      rdy_mode = 0; char_ready = 1'b1;
      wait_done(50);
      chk(mem_w[widx(S0)] == 32'h0000_4241, "mem_unchanged", mem_w[widx(S0)], 32'h0000_4241);

      // the same store while idle goes straight through
      cpu_mem_write = 1'b1;
      @(negedge clk);
      chk(mem_write && mem_addr == S0, "idle_pass_addr", mem_addr, S0);
      chk(mem_write_data == 32'hDEAD_BEEF, "idle_pass_data", mem_write_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      cpu_mem_write = 1'b0;
      chk(mem_w[widx(S0)] == 32'hDEAD_BEEF, "idle_store", mem_w[widx(S0)], 32'hDEAD_BEEF);

      // out-of-range address
      start_op(32'h0000_1000, 1);
      chk(exp_err && exp_edges == 0, "model_range", 32'(exp_edges), 32'd0);
      wait_done(10);
      repeat (3) @(posedge clk);
      #1;
      chk(error == 1'b1, "range_error_held", 32'(error), 32'd1);

      // MAX_LEN=4 instance on eight nonzero bytes
      mem_w[widx(S0)]     = 32'h6463_6261;
      mem_w[widx(S0) + 1] = 32'h6867_6665;
      model(S0, 4, q, e, ed);
      chk(q.size() == 4 && q[0] == 8'h61 && q[3] == 8'h64 && e, "model_maxlen", 32'(q.size()), 32'd4);
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      got = {};
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy4) chk(!mem_write4 && mem_size4 == 2'd0, "dut4_port", {mem_write4, mem_size4}, 32'd0);
         chk(cpu_read_data4 == mem_read_data4, "dut4_mirror", cpu_read_data4, mem_read_data4);
         if (char_valid4 && char_ready) got.push_back(char_data4);
         if (done4) break;
      end
      chk(done4, "dut4_done", 32'(done4), 32'd1);
      chk(got.size() == q.size(), "dut4_count", 32'(got.size()), 32'(q.size()));
      for (int i = 0; i < got.size() && i < q.size(); i++)
         chk(got[i] == q[i], "dut4_char", 32'(got[i]), 32'(q[i]));
      chk(error4 == 1'b1, "dut4_error", 32'(error4), 32'd1);
      @(posedge clk); #1;

      // reset while presenting a character
      mem_w[widx(S0)] = 32'h0000_4241;
      rdy_mode = 2;
      start_op(S0, 0);
      n = 0;
      while (!char_valid && n < 10) begin @(negedge clk); n++; end
      chk(char_valid, "pre_reset_valid", 32'(char_valid), 32'd1);
      @(posedge clk); #2;
      op_active = 0; exp_q = {}; last_err = 0;
      reset = 1'b1;
      #1;
      chk(!char_valid && char_data == 8'd0, "reset_mid_char", {char_valid, char_data}, 32'd0);
      chk(!busy && !done, "reset_mid_busy", {busy, done}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      rdy_mode = 0;
      repeat (6) @(posedge clk);
      #1;

      // randomized strings
      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(0, 7);
         if (n == 0) begin
            case ($urandom_range(0, 2))
               0: a = LO - 32'd1;
               1: a = HI + 32'd1;
               default: a = 32'h0000_1000 + 32'($urandom_range(0, 255));
            endcase
         end else if (n == 1) begin
            for (int w = 254; w <= 256; w++)
               mem_w[w] = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                           8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
            a = HI - 32'($urandom_range(0, 9));
         end else begin
            ed = $urandom_range(0, 240);
            for (int w = 0; w < 8; w++)
               mem_w[ed + w] = {rbyte(), rbyte(), rbyte(), rbyte()};
            a = LO + 32'(ed * 4) + 32'($urandom_range(0, 15));
         end
         rdy_mode = $urandom_range(0, 1);
         if (rdy_mode == 0) char_ready = 1'b1;
         start_op(a, rdy_mode == 0);
         wait_done(5000);
         rdy_mode = 0;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
